// File: rtl/bus_mem_responder_pkg.sv
// Shared types and limits for bus_mem_responder: FSM state encoding, bus width
// and the wait-latency range.
package bus_mem_responder_pkg;

  localparam int XLEN    = 32;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Saturate the requested latency into the counter's range.
  function automatic logic [CNT_W-1:0] clamp_latency(input int lat);
    if (lat > LAT_MAX) return CNT_W'(LAT_MAX);
    if (lat < 0)       return '0;
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/bus_mem_responder_sram_1p.sv
// Single-port byte-writable RAM with a registered read port. Each byte lane is
// its own array so per-byte write enables map onto block RAM cleanly.
module sram_1p #(
  parameter int DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic [3:0]               i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;

      // Read returns the pre-write contents when read and write share a cycle.
      always_ff @(posedge i_clk) begin
        if (i_we[gi]) begin
          mem[i_addr] <= i_wdata[8*gi +: 8];
        end
        q_reg <= mem[i_addr];
      end

      assign o_rdata[8*gi +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/bus_mem_responder.sv
// Bus-to-memory responder: latches one request, waits LATENCY+1 cycles, then
// acks once. Define MEM_RESP_BOUNDS_EN to flag out-of-range addresses as errors.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_err
);

  localparam int              AW  = $clog2(MEM_WORDS);
  localparam logic [CNT_W-1:0] LAT = clamp_latency(LATENCY);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic              wr_reg;
  logic [3:0]        be_reg;
  logic              latch_en;
  logic              addr_err;
  logic [3:0]        mem_we;
  logic [31:0]       mem_q;
  logic [AW-1:0]     mem_idx;
  logic              addr_unused;

  assign mem_idx     = addr_reg[2 +: AW];
  assign addr_unused = &{1'b0, addr_reg[1:0], addr_reg[XLEN-1:2+AW]};

`ifdef MEM_RESP_BOUNDS_EN
  assign addr_err = (addr_reg[XLEN-1:2] >= (XLEN-2)'(MEM_WORDS));
`else
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      be_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (latch_en) begin
        addr_reg  <= i_addr;
        wdata_reg <= i_wr_data;
        wr_reg    <= i_wr_en;
        be_reg    <= i_byte_en;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    latch_en   = 1'b0;
    mem_we     = '0;
    o_ack      = 1'b0;
    o_rd_data  = '0;
    o_err      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_bus_en) begin
          latch_en   = 1'b1;
          cnt_next   = LAT;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The final wait cycle commits writes and launches the RAM read.
        if (cnt_reg == '0) begin
          state_next = ST_RESP;
          if (wr_reg && !addr_err) begin
            mem_we = be_reg;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_RESP: begin
        o_ack      = 1'b1;
        o_err      = addr_err;
        state_next = ST_DONE;
        if (!wr_reg && !addr_err) begin
          o_rd_data = mem_q;
        end
      end
      ST_DONE: begin
        if (!i_bus_en) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  sram_1p #(
    .DEPTH (MEM_WORDS)
  ) u_sram (
    .i_clk   (i_clk),
    .i_we    (mem_we),
    .i_addr  (mem_idx),
    .i_wdata (wdata_reg),
    .o_rdata (mem_q)
  );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Scoreboard bench for bus_mem_responder: LATENCY=1 and LATENCY=3 instances,
// expected responses queued at issue time and popped by per-instance monitors.
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_en  [2];
  logic        wr_en   [2];
  logic [31:0] wr_data [2];
  logic [31:0] addr    [2];
  logic [3:0]  be      [2];
  logic        ack     [2];
  logic [31:0] rd_data [2];
  logic        err     [2];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

`ifdef MEM_RESP_BOUNDS_EN
  localparam logic [31:0] OOB_WR_ERR = 32'd1;
  localparam logic [31:0] OOB_RD_DAT = 32'h0000_0000;
  localparam logic [31:0] OOB_RD_ERR = 32'd1;
  localparam logic [31:0] WORD0_EXP  = 32'hA5A5_A5A5;
`else
  localparam logic [31:0] OOB_WR_ERR = 32'd0;
  localparam logic [31:0] OOB_RD_DAT = 32'h0000_0055;
  localparam logic [31:0] OOB_RD_ERR = 32'd0;
  localparam logic [31:0] WORD0_EXP  = 32'h0000_0055;
`endif

  always #5 clk = ~clk;

  bus_mem_responder #(.MEM_WORDS(1024), .LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en[0]), .i_wr_en(wr_en[0]),
    .i_wr_data(wr_data[0]), .i_addr(addr[0]), .i_byte_en(be[0]),
    .o_ack(ack[0]), .o_rd_data(rd_data[0]), .o_err(err[0])
  );

  bus_mem_responder #(.MEM_WORDS(1024), .LATENCY(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_bus_en(bus_en[1]), .i_wr_en(wr_en[1]),
    .i_wr_data(wr_data[1]), .i_addr(addr[1]), .i_byte_en(be[1]),
    .o_ack(ack[1]), .o_rd_data(rd_data[1]), .o_err(err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack[0] === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut1 ack without request", 32'(ack[0]), 32'd0);
      end else begin
        e = q0.pop_front();
        check("dut1 rd_data", rd_data[0], e.rd);
        check("dut1 err", 32'(err[0]), 32'(e.er));
        $display("[TB] dut1 ack rd_data=0x%08h err=%0d", rd_data[0], err[0]);
      end
    end else begin
      check("dut1 idle rd_data", rd_data[0], 32'd0);
      check("dut1 idle err", 32'(err[0]), 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (ack[1] === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut3 ack without request", 32'(ack[1]), 32'd0);
      end else begin
        e = q1.pop_front();
        check("dut3 rd_data", rd_data[1], e.rd);
        check("dut3 err", 32'(err[1]), 32'(e.er));
        $display("[TB] dut3 ack rd_data=0x%08h err=%0d", rd_data[1], err[1]);
      end
    end else begin
      check("dut3 idle rd_data", rd_data[1], 32'd0);
      check("dut3 idle err", 32'(err[1]), 32'd0);
    end
  end

  // Issue one request, scramble inputs once latched, and check ack latency.
  task automatic req(input int s, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rd, input logic [31:0] exp_er,
                     input int hold, input string name);
    int   n;
    int   lat;
    exp_t e;
    lat  = (s == 0) ? 1 : 3;
    e.rd = exp_rd;
    e.er = exp_er[0];
    @(negedge clk);
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    bus_en[s] = 1'b1; wr_en[s] = w; addr[s] = a; wr_data[s] = d; be[s] = b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        wr_en[s] = ~w; addr[s] = ~a; wr_data[s] = ~d; be[s] = ~b;
      end
    end while (ack[s] !== 1'b1 && n < 40);
    check({name, " ack latency"}, 32'(n), 32'(2 + lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " held no second ack"}, 32'(ack[s]), 32'd0);
    end
    bus_en[s] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_en[i] = 1'b0; wr_en[i] = 1'b0; wr_data[i] = '0; addr[i] = '0; be[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset dut1 ack", 32'(ack[0]), 32'd0);
    check("reset dut3 ack", 32'(ack[1]), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 32'd0, 0, "wr 0x10");
    req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'd0, 0, "rd 0x10");
    req(0, 1'b0, 32'h13, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'd0, 0, "rd 0x13");
    req(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'h0, 32'd0, 0, "wr 0x20 full");
    req(0, 1'b1, 32'h20, 32'h0000_AA00, 4'b0010, 32'h0, 32'd0, 0, "wr 0x20 byte1");
    req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_AA44, 32'd0, 0, "rd 0x20 merged");
    req(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 32'd0, 0, "wr 0x20 no bytes");
    req(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1122_AA44, 32'd0, 0, "rd 0x20 unchanged");
    req(0, 1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 32'h0, 32'd0, 0, "wr 0x0");
    req(0, 1'b1, 32'h1000, 32'h55, 4'hF, 32'h0, OOB_WR_ERR, 0, "wr 0x1000");
    req(0, 1'b0, 32'h0, 32'h0, 4'h0, WORD0_EXP, 32'd0, 0, "rd 0x0");
    req(0, 1'b0, 32'h1000, 32'h0, 4'h0, OOB_RD_DAT, OOB_RD_ERR, 0, "rd 0x1000");
    req(0, 1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 32'h0, 32'd0, 0, "wr 0x30");

    // Write to 0x30 aborted by reset during WAIT: no ack, no array change.
    @(negedge clk);
    bus_en[0] = 1'b1; wr_en[0] = 1'b1; addr[0] = 32'h30; wr_data[0] = 32'h0; be[0] = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    bus_en[0] = 1'b0;
    #1;
    check("rst dut1 ack", 32'(ack[0]), 32'd0);
    check("rst dut1 rd_data", rd_data[0], 32'd0);
    check("rst dut1 err", 32'(err[0]), 32'd0);
    check("rst dut3 ack", 32'(ack[1]), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst hold dut1 ack", 32'(ack[0]), 32'd0);
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post-abort dut1 ack", 32'(ack[0]), 32'd0);
    end
    req(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 32'd0, 0, "rd 0x30 after abort");

    req(1, 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 32'd0, 0, "lat3 wr 0x40");
    req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 32'd0, 4, "lat3 rd hold");
    req(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 32'd0, 0, "lat3 rd again");

    repeat (3) @(negedge clk);
    check("dut1 leftover expectations", 32'(q0.size()), 32'd0);
    check("dut3 leftover expectations", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
